// File: rtl/frameblock_ring_controller.sv
// Ring of NUM_BUFS frameblock RAMs between the drawing pipeline and the display.
// Drawing fills buffers in ring order, display drains completed ones, and an
// optional clear engine refills released buffers with CLEAR_VAL before reuse.
module frameblock_ring_controller #(
   parameter int              NUM_BUFS  = 3,
   parameter int              DATA_W    = 16,
   parameter int              ADDR_W    = 10,
   parameter int              ID_W      = 7,
   parameter int              CLEAR_EN  = 1,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [DATA_W-1:0]              draw_wrdata,
   input  logic [ADDR_W-1:0]              draw_wraddr,
   input  logic                           draw_we,
   input  logic [ADDR_W-1:0]              draw_rdaddr,
   output logic [DATA_W-1:0]              draw_rddata,
   input  logic [ID_W-1:0]                draw_id,
   input  logic                           draw_next,
   output logic                           draw_ready,
   input  logic [ADDR_W-1:0]              display_rdaddr,
   output logic [DATA_W-1:0]              display_rddata,
   output logic [ID_W-1:0]                display_id,
   input  logic                           display_next,
   output logic                           display_ready,
   output logic [$clog2(NUM_BUFS+1)-1:0]  fill_level,
   output logic                           clear_busy
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int PTR_W = $clog2(NUM_BUFS);
   localparam int FL_W  = $clog2(NUM_BUFS + 1);

   typedef enum logic [1:0] {ST_FREE, ST_DRAW, ST_FULL, ST_CLEAR} buf_state_t;

   // With clearing enabled every buffer starts dirty and must be cleared first.
   localparam buf_state_t ST_INIT    = (CLEAR_EN != 0) ? ST_CLEAR : ST_FREE;
   localparam buf_state_t ST_RELEASE = (CLEAR_EN != 0) ? ST_CLEAR : ST_FREE;

   buf_state_t        state_q [NUM_BUFS];
   buf_state_t        state_d [NUM_BUFS];
   logic [ID_W-1:0]   id_q    [NUM_BUFS];
   logic [ID_W-1:0]   id_d    [NUM_BUFS];
   logic [PTR_W-1:0]  dptr_q, dptr_d;
   logic [PTR_W-1:0]  vptr_q, vptr_d;
   logic [PTR_W-1:0]  cptr_q, cptr_d;
   logic [FL_W-1:0]   fill_q, fill_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   // Held low for the first cycle after reset so the clear engine starts on a clean edge.
   logic              run_q;
   logic [ADDR_W-1:0] draw_addr_q, disp_addr_q;
   logic [PTR_W-1:0]  dsel_q, vsel_q;

   logic              draw_adv, disp_adv, clear_act, clear_done;
   logic [DATA_W-1:0] draw_rd [NUM_BUFS];
   logic [DATA_W-1:0] disp_rd [NUM_BUFS];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(NUM_BUFS - 1)) ? '0 : p + 1'b1;
   endfunction

   assign draw_ready    = (state_q[dptr_q] == ST_FREE);
   assign display_ready = (state_q[vptr_q] == ST_FULL);
   assign display_id    = id_q[vptr_q];
   assign fill_level    = fill_q;
   assign clear_act     = run_q && (state_q[cptr_q] == ST_CLEAR);
   assign clear_busy    = clear_act;
   assign clear_done    = clear_act && (clr_addr_q == ADDR_W'(DEPTH - 1));
   assign draw_adv      = draw_next && draw_ready;
   assign disp_adv      = display_next && display_ready;

   // Ring bookkeeping: buffer states, IDs, pointers, fill count, clear address.
   always_comb begin
      for (int i = 0; i < NUM_BUFS; i++) begin
         state_d[i] = state_q[i];
         id_d[i]    = id_q[i];
      end
      dptr_d     = dptr_q;
      vptr_d     = vptr_q;
      cptr_d     = cptr_q;
      fill_d     = fill_q;
      clr_addr_d = clear_act ? clr_addr_q + 1'b1 : '0;
      // dptr, vptr and cptr buffers are FREE, FULL and CLEAR respectively,
      // so these three updates never target the same entry.
      if (draw_adv) begin
         state_d[dptr_q] = ST_FULL;
         id_d[dptr_q]    = draw_id;
         dptr_d          = ptr_inc(dptr_q);
      end
      if (disp_adv) begin
         state_d[vptr_q] = ST_RELEASE;
         vptr_d          = ptr_inc(vptr_q);
      end
      if (clear_done) begin
         state_d[cptr_q] = ST_FREE;
         cptr_d          = ptr_inc(cptr_q);
      end
      case ({draw_adv, disp_adv})
         2'b10:   fill_d = fill_q + 1'b1;
         2'b01:   fill_d = fill_q - 1'b1;
         default: fill_d = fill_q;
      endcase
   end

   // Control registers and read-side address/select pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BUFS; i++) begin
            state_q[i] <= ST_INIT;
            id_q[i]    <= '0;
         end
         dptr_q      <= '0;
         vptr_q      <= '0;
         cptr_q      <= '0;
         fill_q      <= '0;
         clr_addr_q  <= '0;
         run_q       <= 1'b0;
         draw_addr_q <= '0;
         disp_addr_q <= '0;
         dsel_q      <= '0;
         vsel_q      <= '0;
      end else begin
         for (int i = 0; i < NUM_BUFS; i++) begin
            state_q[i] <= state_d[i];
            id_q[i]    <= id_d[i];
         end
         dptr_q      <= dptr_d;
         vptr_q      <= vptr_d;
         cptr_q      <= cptr_d;
         fill_q      <= fill_d;
         clr_addr_q  <= clr_addr_d;
         run_q       <= 1'b1;
         draw_addr_q <= draw_rdaddr;
         disp_addr_q <= display_rdaddr;
         // Select follows the pointer of the issuing cycle, not the advanced one.
         dsel_q      <= dptr_q;
         vsel_q      <= vptr_q;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BUFS; gi++) begin : g_buf
         logic [DATA_W-1:0] mem [DEPTH];
         logic              we;
         logic [ADDR_W-1:0] wa;
         logic [DATA_W-1:0] wd;

         // Write port arbitration: clear engine owns a CLEAR buffer, else the draw side.
         always_comb begin
            we = 1'b0;
            wa = draw_wraddr;
            wd = draw_wrdata;
            if (clear_act && (cptr_q == PTR_W'(gi))) begin
               we = 1'b1;
               wa = clr_addr_q;
               wd = CLEAR_VAL;
            end else if (draw_we && draw_ready && (dptr_q == PTR_W'(gi))) begin
               we = 1'b1;
            end
         end

         // RAM write; reads use the registered addresses below.
         always_ff @(posedge clk) begin
            if (we) mem[wa] <= wd;
         end

         assign draw_rd[gi] = mem[draw_addr_q];
         assign disp_rd[gi] = mem[disp_addr_q];
      end
   endgenerate

   assign draw_rddata    = draw_rd[dsel_q];
   assign display_rddata = disp_rd[vsel_q];

endmodule

// File: tb/tb_frameblock_ring_controller.sv
// Self-checking bench for frameblock_ring_controller (default parameters).
module tb_frameblock_ring_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] draw_wrdata = '0;
   logic [9:0]  draw_wraddr = '0;
   logic        draw_we = 1'b0;
   logic [9:0]  draw_rdaddr = '0;
   logic [15:0] draw_rddata;
   logic [6:0]  draw_id = '0;
   logic        draw_next = 1'b0;
   logic        draw_ready;
   logic [9:0]  display_rdaddr = '0;
   logic [15:0] display_rddata;
   logic [6:0]  display_id;
   logic        display_next = 1'b0;
   logic        display_ready;
   logic [1:0]  fill_level;
   logic        clear_busy;

   frameblock_ring_controller dut (
      .clk(clk), .rst_n(rst_n),
      .draw_wrdata(draw_wrdata), .draw_wraddr(draw_wraddr), .draw_we(draw_we),
      .draw_rdaddr(draw_rdaddr), .draw_rddata(draw_rddata),
      .draw_id(draw_id), .draw_next(draw_next), .draw_ready(draw_ready),
      .display_rdaddr(display_rdaddr), .display_rddata(display_rddata),
      .display_id(display_id), .display_next(display_next),
      .display_ready(display_ready), .fill_level(fill_level), .clear_busy(clear_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp;
   } vec_t;

   typedef struct {
      string       nm;
      bit          disp;
      logic [15:0] exp;
   } sb_t;

   vec_t vecs [4];
   sb_t  sbq [$];
   int   vec_cnt = 0;
   int   err_cnt = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end else begin
         $display("ok   %s: %0h", nm, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive a read address and queue the value it must return one cycle later.
   task automatic push_rd(input bit disp, input logic [9:0] a, input logic [15:0] e, input string nm);
      if (disp) display_rdaddr = a;
      else      draw_rdaddr    = a;
      sbq.push_back('{nm, disp, e});
   endtask

   task automatic drain();
      sb_t s;
      while (sbq.size() > 0) begin
         s = sbq.pop_front();
         check(s.nm, s.disp ? {16'h0, display_rddata} : {16'h0, draw_rddata}, {16'h0, s.exp});
      end
   endtask

   task automatic read1(input bit disp, input logic [9:0] a, input logic [15:0] e, input string nm);
      push_rd(disp, a, e, nm);
      step();
      drain();
   endtask

   task automatic write1(input logic [9:0] a, input logic [15:0] d);
      draw_we = 1'b1; draw_wraddr = a; draw_wrdata = d;
      step();
      draw_we = 1'b0;
   endtask

   task automatic pulse(input bit dn, input bit vn, input logic [6:0] id);
      draw_next = dn; display_next = vn; draw_id = id;
      step();
      draw_next = 1'b0; display_next = 1'b0;
   endtask

   // Release reset and measure cycles until buffer 0 is ready to draw.
   task automatic release_and_measure(input string tag);
      int n;
      rst_n = 1'b1;
      n = 0;
      check({tag, "_ready_at_release"}, {31'h0, draw_ready}, 32'h0);
      step(); n++;
      check({tag, "_busy_first_cycle"}, {31'h0, clear_busy}, 32'h1);
      while (!draw_ready && n < 2000) begin
         step(); n++;
      end
      check({tag, "_ready_latency"}, n, 32'd1025);
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (clear_busy && n < 5000) begin
         step(); n++;
      end
      check(nm, {31'h0, clear_busy}, 32'h0);
   endtask

   initial begin
      int n;
      vecs[0] = '{10'd5,    16'hF800, 16'hF800};
      vecs[1] = '{10'd0,    16'h1234, 16'h1234};
      vecs[2] = '{10'd1023, 16'hABCD, 16'hABCD};
      vecs[3] = '{10'd512,  16'h07E0, 16'h07E0};

      // Reset state
      step(); step();
      check("rst_draw_ready", {31'h0, draw_ready}, 32'h0);
      check("rst_display_ready", {31'h0, display_ready}, 32'h0);
      check("rst_fill", {30'h0, fill_level}, 32'h0);
      check("rst_clear_busy", {31'h0, clear_busy}, 32'h0);
      check("rst_display_id", {25'h0, display_id}, 32'h0);

      // Scenario 1: initial clear of buffer 0
      release_and_measure("init");
      for (int i = 0; i < 4; i++) read1(1'b0, vecs[i].addr, 16'h0000, "buf0_cleared");

      // Scenario 2: table writes, hand off with id 12, display reads
      for (int i = 0; i < 4; i++) begin
         write1(vecs[i].addr, vecs[i].wdata);
         read1(1'b0, vecs[i].addr, vecs[i].exp, "draw_rmw_read");
      end
      pulse(1'b1, 1'b0, 7'd12);
      check("s2_display_ready", {31'h0, display_ready}, 32'h1);
      check("s2_display_id", {25'h0, display_id}, 32'd12);
      check("s2_fill", {30'h0, fill_level}, 32'd1);
      check("s2_draw_ready_buf1_clearing", {31'h0, draw_ready}, 32'h0);
      for (int i = 0; i < 4; i++) read1(1'b1, vecs[i].addr, vecs[i].exp, "display_read");

      // Scenario 3: fill the ring
      wait_idle("s3_clear_idle");
      check("s3_draw_ready", {31'h0, draw_ready}, 32'h1);
      write1(10'd5, 16'h1111);
      pulse(1'b1, 1'b0, 7'd20);
      write1(10'd5, 16'h2222);
      pulse(1'b1, 1'b0, 7'd21);
      check("s3_fill_full", {30'h0, fill_level}, 32'd3);
      check("s3_draw_ready_full", {31'h0, draw_ready}, 32'h0);
      write1(10'd5, 16'hDEAD);
      pulse(1'b1, 1'b0, 7'd99);
      check("s3_fill_after_ignored_next", {30'h0, fill_level}, 32'd3);
      check("s3_id_after_ignored_next", {25'h0, display_id}, 32'd12);
      read1(1'b0, 10'd5, 16'hF800, "s3_dropped_write_draw");
      read1(1'b1, 10'd5, 16'hF800, "s3_dropped_write_disp");

      // Scenario 5: release buffer 0, measure clear, reuse
      pulse(1'b0, 1'b1, 7'd0);
      check("s5_fill", {30'h0, fill_level}, 32'd2);
      check("s5_display_id", {25'h0, display_id}, 32'd20);
      check("s5_clear_busy", {31'h0, clear_busy}, 32'h1);
      n = 0;
      while (clear_busy && n < 3000) begin
         step(); n++;
      end
      check("s5_clear_cycles", n, 32'd1024);
      check("s5_draw_ready", {31'h0, draw_ready}, 32'h1);
      read1(1'b0, 10'd5, 16'h0000, "s5_reused_cleared");
      read1(1'b1, 10'd5, 16'h1111, "s5_display_buf1");

      // Scenario 4: simultaneous pulses at fill_level 1, with reads in flight
      pulse(1'b0, 1'b1, 7'd0);
      check("s4_fill_pre", {30'h0, fill_level}, 32'd1);
      check("s4_display_id_pre", {25'h0, display_id}, 32'd21);
      write1(10'd7, 16'h3333);
      push_rd(1'b1, 10'd5, 16'h2222, "s4_disp_read_across_advance");
      push_rd(1'b0, 10'd7, 16'h3333, "s4_draw_read_across_advance");
      pulse(1'b1, 1'b1, 7'd30);
      drain();
      check("s4_fill_same", {30'h0, fill_level}, 32'd1);
      check("s4_display_id", {25'h0, display_id}, 32'd30);
      check("s4_display_ready", {31'h0, display_ready}, 32'h1);
      check("s4_draw_ready", {31'h0, draw_ready}, 32'h0);
      read1(1'b1, 10'd7, 16'h3333, "s4_display_new_block");

      // Scenario 6: reset mid-clear
      check("s6_busy_before", {31'h0, clear_busy}, 32'h1);
      for (int i = 0; i < 10; i++) step();
      rst_n = 1'b0;
      #1;
      check("s6_draw_ready", {31'h0, draw_ready}, 32'h0);
      check("s6_display_ready", {31'h0, display_ready}, 32'h0);
      check("s6_fill", {30'h0, fill_level}, 32'h0);
      check("s6_clear_busy", {31'h0, clear_busy}, 32'h0);
      check("s6_display_id", {25'h0, display_id}, 32'h0);
      step(); step();
      release_and_measure("rerst");
      read1(1'b0, 10'd7, 16'h0000, "s6_buf0_recleared");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
